// File: rtl/core_block_sequencer.sv
// Block sequencer: accepts one thread block, splits it into warps, issues
// them to the warp scheduler and reports completion once all warps retire.
module core_block_sequencer #(
  parameter int WARP_SIZE    = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_start,
  input  logic signed [31:0]   core_block_id,
  input  logic [31:0]          num_threads,
  input  logic [31:0]          block_dim,
  output logic                 core_done,
  output logic                 busy,
  output logic                 warp_valid,
  input  logic                 warp_ready,
  output logic [31:0]          warp_base_thread,
  output logic [WARP_SIZE-1:0] warp_lane_mask,
  output logic [15:0]          warp_idx,
  input  logic                 warp_retire,
  output logic                 retire_err
);

  localparam int LW = $clog2(WARP_SIZE);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, DRAIN, DONE} state_t;

  state_t               state_q, state_n;
  logic signed [31:0]   id_q;
  logic [31:0]          nthr_q, bdim_q;
  logic [31:0]          base_q;     // global thread id of the next warp to load
  logic [31:0]          nwarps_q;
  logic [31:0]          k_q;        // number of descriptors loaded so far
  logic [LW-1:0]        rem_q;      // active mod WARP_SIZE
  logic [IW-1:0]        inflight_q, inflight_n;

  logic [31:0]          blk_base, left, active, nwarps;
  logic [32:0]          wsum;
  logic                 skip, xfer, ret_ok, last_out;
  logic [WARP_SIZE-1:0] mask_c;

  // Block geometry from the latched assignment, consumed in SETUP
  always_comb begin
    blk_base = $unsigned(id_q) * bdim_q;
    left     = nthr_q - blk_base;
    active   = '0;
    if (blk_base < nthr_q) active = (bdim_q < left) ? bdim_q : left;
    wsum     = {1'b0, active} + 33'(WARP_SIZE - 1);
    nwarps   = 32'(wsum >> LW);
    skip     = id_q[31] || (active == '0);
  end

  // Handshake bookkeeping; a retire with nothing in flight is ignored here
  always_comb begin
    xfer       = warp_valid && warp_ready;
    ret_ok     = warp_retire && (inflight_q != '0);
    inflight_n = inflight_q + IW'(xfer) - IW'(ret_ok);
    // the descriptor on the bus is the last one once every warp is loaded
    last_out   = (k_q == nwarps_q);
    mask_c     = '1;
    if ((k_q == nwarps_q - 32'd1) && (rem_q != '0))
      mask_c = ~({WARP_SIZE{1'b1}} << rem_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:  if (core_start) state_n = SETUP;
      SETUP: state_n = skip ? DONE : ISSUE;
      ISSUE: if (xfer && last_out) state_n = DRAIN;
      DRAIN: if (inflight_q == '0) state_n = DONE;
      // leave only after core_done has been visible to the dispatcher
      DONE:  if (core_done && !core_start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: latch block, load warp descriptors, track in-flight warps
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q             <= '0;
      nthr_q           <= '0;
      bdim_q           <= '0;
      base_q           <= '0;
      nwarps_q         <= '0;
      k_q              <= '0;
      rem_q            <= '0;
      inflight_q       <= '0;
      core_done        <= 1'b0;
      warp_valid       <= 1'b0;
      warp_base_thread <= '0;
      warp_lane_mask   <= '0;
      warp_idx         <= '0;
      retire_err       <= 1'b0;
    end else begin
      retire_err <= retire_err | (warp_retire && (inflight_q == '0));
      inflight_q <= inflight_n;
      core_done  <= (state_q == DONE) && (state_n == DONE);
      case (state_q)
        IDLE: if (core_start) begin
          id_q   <= core_block_id;
          nthr_q <= num_threads;
          bdim_q <= block_dim;
        end
        SETUP: begin
          base_q   <= blk_base;
          nwarps_q <= nwarps;
          rem_q    <= active[LW-1:0];
          k_q      <= '0;
        end
        ISSUE: begin
          // the output slot is free when empty or being consumed this cycle
          if (!warp_valid || xfer) begin
            if ((k_q != nwarps_q) && (inflight_n < IW'(MAX_INFLIGHT))) begin
              warp_valid       <= 1'b1;
              warp_base_thread <= base_q;
              warp_lane_mask   <= mask_c;
              warp_idx         <= k_q[15:0];
              base_q           <= base_q + 32'(WARP_SIZE);
              k_q              <= k_q + 32'd1;
            end else begin
              warp_valid <= 1'b0;
            end
          end
        end
        default: warp_valid <= 1'b0;
      endcase
    end
  end

endmodule
